// File: rtl/uart_result_framer_if.sv
// uart_result_framer_if: result push, status and UART_TX byte handshake bundle
interface uart_result_framer_if #(parameter int NB_DATA = 8);
  logic               i_valid;
  logic [NB_DATA-1:0] i_result;
  logic               o_full;
  logic               o_overflow;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_tx_data;
  logic               i_txDone;
  logic               o_busy;
  logic               o_frame_done;
  logic               o_timeout;
  modport master (
    output i_valid, i_result, i_txDone,
    input  o_full, o_overflow, o_tx_start, o_tx_data, o_busy, o_frame_done, o_timeout
  );
  modport slave (
    input  i_valid, i_result, i_txDone,
    output o_full, o_overflow, o_tx_start, o_tx_data, o_busy, o_frame_done, o_timeout
  );
endinterface

// File: rtl/uart_result_framer.sv
// uart_result_framer: queues ALU results and sends each as {HDR, result, HDR^result} to UART_TX
module uart_result_framer #(
  parameter int                 NB_DATA    = 8,
  parameter int                 FIFO_DEPTH = 4,
  parameter int                 NB_ADDR    = 2,
  parameter logic [NB_DATA-1:0] HDR_BYTE   = 8'h40,
  parameter int                 NB_TOUT    = 16,
  parameter int                 TIMEOUT    = 50000
) (
  input logic                clk,
  input logic                i_rst_n,
  uart_result_framer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t               state, state_n;
  logic [NB_DATA-1:0]   mem [FIFO_DEPTH];
  logic [NB_ADDR-1:0]   rd_ptr, wr_ptr;
  logic [NB_ADDR:0]     count, count_n;
  logic [1:0]           idx, idx_n;
  logic [NB_TOUT-1:0]   tout, tout_n;
  logic [NB_DATA-1:0]   data_reg, data_n, chk_reg, chk_n, tx_data_n;
  logic                 push, pop, fd_n, to_n;
  assign push    = bus.i_valid & ~bus.o_full;
  assign pop     = (state == IDLE) && (count != '0);
  assign count_n = count + {{NB_ADDR{1'b0}}, push} - {{NB_ADDR{1'b0}}, pop};
  // next state: pop a result into a new frame, pulse each byte, wait for done or give up
  always_comb begin
    state_n = state;
    idx_n   = idx;
    tout_n  = tout;
    data_n  = data_reg;
    chk_n   = chk_reg;
    fd_n    = 1'b0;
    to_n    = 1'b0;
    unique case (state)
      IDLE: if (pop) begin
        data_n  = mem[rd_ptr];
        chk_n   = HDR_BYTE ^ mem[rd_ptr];
        idx_n   = 2'd0;
        state_n = SEND;
      end
      SEND: begin
        tout_n  = '0;
        state_n = WAIT;
      end
      WAIT: if (bus.i_txDone) begin
        fd_n    = idx == 2'd2;
        idx_n   = idx == 2'd2 ? idx : idx + 2'd1;
        state_n = idx == 2'd2 ? IDLE : SEND;
      end else begin
        tout_n  = tout + NB_TOUT'(1);
        to_n    = tout == NB_TOUT'(TIMEOUT - 2);
        state_n = to_n ? IDLE : WAIT;
      end
      default: state_n = IDLE;
    endcase
    tx_data_n = state_n != SEND ? bus.o_tx_data :
                idx_n == 2'd0   ? HDR_BYTE :
                idx_n == 2'd1   ? data_n : chk_n;
  end
  // FSM state and frame context
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      tout     <= '0;
      data_reg <= '0;
      chk_reg  <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      tout     <= tout_n;
      data_reg <= data_n;
      chk_reg  <= chk_n;
    end
  // FIFO bookkeeping and registered outputs
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      bus.o_full       <= 1'b0;
      bus.o_overflow   <= 1'b0;
      bus.o_tx_start   <= 1'b0;
      bus.o_tx_data    <= '0;
      bus.o_busy       <= 1'b0;
      bus.o_frame_done <= 1'b0;
      bus.o_timeout    <= 1'b0;
    end else begin
      rd_ptr           <= rd_ptr + NB_ADDR'(pop);
      wr_ptr           <= wr_ptr + NB_ADDR'(push);
      count            <= count_n;
      bus.o_full       <= count_n == (NB_ADDR+1)'(FIFO_DEPTH);
      bus.o_overflow   <= bus.o_overflow | (bus.i_valid & bus.o_full);
      bus.o_tx_start   <= state_n == SEND;
      bus.o_tx_data    <= tx_data_n;
      bus.o_busy       <= state_n != IDLE;
      bus.o_frame_done <= fd_n;
      bus.o_timeout    <= to_n;
    end
  // result storage
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.i_result;
endmodule

// File: tb/tb_uart_result_framer.sv
// tb_uart_result_framer: random and directed frames checked each cycle against a queue-based model
module tb_uart_result_framer;
  localparam int          DEPTH = 4;
  localparam int          TO    = 24;
  localparam logic [7:0]  HDR   = 8'h40;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  uart_result_framer_if #(.NB_DATA(8)) bus();
  uart_result_framer #(.NB_DATA(8), .FIFO_DEPTH(DEPTH), .NB_ADDR(2), .HDR_BYTE(HDR),
                       .NB_TOUT(16), .TIMEOUT(TO)) dut (.clk(clk), .i_rst_n(rst_n), .bus(bus));
  int vectors = 0, miscompares = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Reference: results queue, current frame bytes, byte number, idle-wait cycles.
  logic [7:0] q[$];
  logic [7:0] fr[3];
  logic [7:0] v;
  int  phase = 0, bidx = 0, wcnt = 0;
  bit  was_full;
  logic e_full = 0, e_ovf = 0, e_start = 0, e_busy = 0, e_fd = 0, e_to = 0;
  logic [7:0] e_data = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      phase = 0; bidx = 0; wcnt = 0;
      e_full = 0; e_ovf = 0; e_start = 0; e_data = 0; e_busy = 0; e_fd = 0; e_to = 0;
    end else begin
      was_full = q.size() == DEPTH;
      e_start = 0; e_fd = 0; e_to = 0;
      if (phase == 0) begin
        if (q.size() > 0) begin
          v = q.pop_front();
          fr = '{HDR, v, HDR ^ v};
          bidx = 0; phase = 1; e_start = 1; e_data = fr[0];
        end
      end else if (phase == 1) begin
        phase = 2; wcnt = 0;
      end else if (bus.i_txDone) begin
        if (bidx == 2) begin phase = 0; e_fd = 1; end
        else begin bidx++; phase = 1; e_start = 1; e_data = fr[bidx]; end
      end else begin
        wcnt++;
        if (wcnt == TO - 1) begin phase = 0; e_to = 1; end
      end
      if (bus.i_valid) begin
        if (was_full) e_ovf = 1;
        else q.push_back(bus.i_result);
      end
      e_full = q.size() == DEPTH;
      e_busy = phase != 0;
    end
  end
  logic [7:0] log_b[$];
  int log_c[$];
  int fd_cnt = 0, to_cyc = -1;
  bit full_seen = 0;
  always @(negedge clk) begin
    chk("full", bus.o_full, e_full);
    chk("overflow", bus.o_overflow, e_ovf);
    chk("tx_start", bus.o_tx_start, e_start);
    chk("tx_data", bus.o_tx_data, e_data);
    chk("busy", bus.o_busy, e_busy);
    chk("frame_done", bus.o_frame_done, e_fd);
    chk("timeout", bus.o_timeout, e_to);
    if (bus.o_tx_start) begin log_b.push_back(bus.o_tx_data); log_c.push_back(cyc); end
    if (bus.o_frame_done) fd_cnt++;
    if (bus.o_timeout) to_cyc = cyc;
    if (bus.o_full) full_seen = 1;
  end
  int tx_delay = 4, cnt = -1;
  bit stray_en = 0;
  always @(negedge clk) begin
    if (!rst_n) cnt = -1;
    else if (bus.o_tx_start) cnt = tx_delay;
    else if (cnt > 0) cnt--;
    bus.i_txDone = rst_n && (cnt == 0 || (stray_en && $urandom_range(0, 7) == 0));
    if (cnt == 0) cnt = -1;
  end
  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic push(input logic [7:0] d);
    bus.i_valid = 1; bus.i_result = d; tick(); bus.i_valid = 0;
  endtask
  task automatic drain(input int limit);
    int n = 0;
    while ((e_busy || q.size() > 0 || bus.o_busy) && n < limit) begin tick(); n++; end
    if (n >= limit) begin
      vectors++; miscompares++;
      $display("FAIL drain: still busy after %0d cycles", limit);
    end
  endtask
  int k, base, fd0, n;
  initial begin
    bus.i_valid = 0; bus.i_result = 0;
    tick(3);
    chk("rst_start", bus.o_tx_start, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_ovf", bus.o_overflow, 0);
    rst_n = 1; tick(2);
    tx_delay = 10; k = cyc; base = log_b.size(); fd0 = fd_cnt;
    push(8'h5A); drain(200);
    chk("t1_nbytes", log_b.size() - base, 3);
    if (log_b.size() >= base + 3) begin
      chk("t1_b0", log_b[base], 8'h40);
      chk("t1_b1", log_b[base+1], 8'h5A);
      chk("t1_b2", log_b[base+2], 8'h1A);
      chk("t1_latency", log_c[base] - k, 2);
      chk("t1_gap", log_c[base+1] - log_c[base], 11);
    end
    chk("t1_frame_done", fd_cnt - fd0, 1);
    chk("t1_busy_low", bus.o_busy, 0);
    tx_delay = 6; base = log_b.size(); full_seen = 0;
    for (int i = 1; i <= 6; i++) begin bus.i_valid = 1; bus.i_result = 8'(i); tick(); end
    bus.i_valid = 0; drain(1000);
    chk("t2_nbytes", log_b.size() - base, 15);
    if (log_b.size() >= base + 15)
      for (int i = 0; i < 5; i++) chk("t2_order", log_b[base+3*i+1], i + 1);
    chk("t2_full_seen", full_seen, 1);
    chk("t2_overflow", bus.o_overflow, 1);
    rst_n = 0; tick(); rst_n = 1; tick();
    chk("t3_ovf_cleared", bus.o_overflow, 0);
    tx_delay = -1; to_cyc = -1; base = log_b.size();
    push(8'h33); push(8'h44);
    n = 0;
    while (to_cyc < 0 && n < 200) begin tick(); n++; end
    tx_delay = 3;
    if (to_cyc < 0) begin
      vectors++; miscompares++;
      $display("FAIL t3_timeout: no o_timeout within 200 cycles");
    end else begin
      chk("t3_to_delay", to_cyc - log_c[base], TO);
      chk("t3_busy_low", bus.o_busy, 0);
    end
    drain(200);
    chk("t3_nbytes", log_b.size() - base, 4);
    if (log_b.size() >= base + 4) begin
      chk("t3_next_res", log_b[base+2], 8'h44);
      chk("t3_next_chk", log_b[base+3], 8'h04);
    end
    tx_delay = 5; base = log_b.size();
    push(8'h77); push(8'h12); push(8'h34);
    n = 0;
    while (log_b.size() < base + 2 && n < 200) begin tick(); n++; end
    if (n >= 200) begin
      vectors++; miscompares++;
      $display("FAIL t4_reach: byte 1 never started");
    end
    tick(2); #2;
    rst_n = 0; #1;
    chk("t4_full", bus.o_full, 0);
    chk("t4_ovf", bus.o_overflow, 0);
    chk("t4_start", bus.o_tx_start, 0);
    chk("t4_data", bus.o_tx_data, 0);
    chk("t4_busy", bus.o_busy, 0);
    chk("t4_fd", bus.o_frame_done, 0);
    chk("t4_to", bus.o_timeout, 0);
    tick(2); rst_n = 1; n = log_b.size();
    tick(30);
    chk("t4_no_resume", log_b.size(), n);
    stray_en = 1; fd0 = fd_cnt; n = log_b.size();
    tick(40); stray_en = 0;
    chk("t5_no_start", log_b.size(), n);
    chk("t5_no_fd", fd_cnt, fd0);
    chk("t5_busy", bus.o_busy, 0);
    tx_delay = 2; base = log_b.size();
    push(8'h40); drain(100);
    if (log_b.size() >= base + 3) chk("t6_chk_40", log_b[base+2], 8'h00);
    else chk("t6_n1", log_b.size() - base, 3);
    push(8'hFF); drain(100);
    if (log_b.size() >= base + 6) chk("t6_chk_ff", log_b[base+5], 8'hBF);
    else chk("t6_n2", log_b.size() - base, 6);
    repeat (400) begin
      if ($urandom_range(0, 19) == 0) tx_delay = $urandom_range(0, 9) == 0 ? -1 : int'($urandom_range(1, 8));
      stray_en = $urandom_range(0, 3) == 0;
      bus.i_valid = $urandom_range(0, 1);
      bus.i_result = 8'($urandom);
      tick();
    end
    bus.i_valid = 0; stray_en = 0; tx_delay = 3;
    drain(2000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
